// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MULTI    = 2'd2
  } state_e;

  // One enable per pipeline-register boundary plus the three bubble loads.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } stage_ctrl_t;

  localparam logic [31:0] REG_ZERO = '0;

  // Canned control words for each pipeline response.
  localparam stage_ctrl_t CTRL_FREEZE   = '{default: 1'b0};
  localparam stage_ctrl_t CTRL_RUN      = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                            ex_mem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_BRANCH   = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                            ex_mem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                            ex_mem_flush: 1'b0};
  // Hold PC/IF/ID/EX, keep draining MEM/WB and feed bubbles into EX/MEM.
  localparam stage_ctrl_t CTRL_MULTI    = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                            ex_mem_flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the instruction in ID reads the
// destination of a load currently in EX (x0 never creates a hazard).
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  load_use_o
);

  logic rd_nonzero;
  logic hit_rs1;
  logic hit_rs2;

  assign rd_nonzero = (ex_rd_i != REG_ZERO[REG_ADDR_W-1:0]);
  assign hit_rs1    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign hit_rs2    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i & rd_nonzero & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: sole driver of the enables and flushes of
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves memory wait states, multi-cycle
// EX ops, taken branches and load-use hazards (in that priority order).
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULTI_LAT  = 4,
  parameter int CNT_W      = $clog2(MULTI_LAT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_multi_start,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  ex_multi_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_cnt
`endif
);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;     // state to resume after a memory wait
  state_e           mode;             // state whose rules apply this cycle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  logic             load_use;
  logic             busy;
  stage_ctrl_t      ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  assign mem_stall = mem_req & ~mem_ready;
  // Once memory is ready, the wait cycle behaves as the interrupted state.
  assign mode      = (state_q == MEM_WAIT) ? ret_q : state_q;

  // Next-state, countdown and control word selection (zero-latency decision).
  always_comb begin
    ctrl    = CTRL_FREEZE;
    busy    = 1'b0;
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    if (!rst_n) begin
      ctrl = CTRL_FREEZE;
    end else if (mem_stall) begin
      // Global freeze; the MULTI countdown is held as well.
      ctrl    = CTRL_FREEZE;
      busy    = (mode == MULTI) && (cnt_q != '0);
      state_d = MEM_WAIT;
      ret_d   = mode;
    end else begin
      state_d = mode;
      case (mode)
        MULTI: begin
          if (cnt_q != '0) begin
            ctrl  = CTRL_MULTI;
            busy  = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            ctrl    = CTRL_RUN;
            state_d = RUN;
          end
        end
        default: begin
          if (ex_multi_start) begin
            ctrl    = CTRL_MULTI;
            busy    = 1'b1;
            cnt_d   = CNT_W'(MULTI_LAT - 2);
            state_d = MULTI;
          end else if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
      endcase
    end
  end

  // FSM state, saved return state and multi-cycle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_flush  = ctrl.ex_mem_flush;
  assign ex_multi_busy = busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // Count front-end stall cycles and IF/ID flushes; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_en)      stall_q <= stall_q + 32'd1;
      if (ctrl.if_id_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flush_cnt    = flush_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage core's pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates one enable and one flush per boundary, so each pipeline register holds, advances or loads a bubble every cycle.
- Resolves four hazard sources: load-use, taken branch, multi-cycle EX ops and data-memory wait states.
- Sits beside the datapath in the core top; it is the only driver of pipeline-register enables and flushes.

Parameters:
- REG_ADDR_W, 5, register-file index width.
- MULTI_LAT, 4, total EX occupancy in cycles of a multi-cycle op (mul/div); legal range 2..16.
- CNT_W, $clog2(MULTI_LAT), width of the multi-cycle countdown.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  the EX instruction redirects the PC this cycle.
- ex_multi_start  in  1  the EX instruction is multi-cycle; valid in RUN only.
- mem_req  in  1  the MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a NOP into that register on the next edge; qualified by the register's own enable.
- ex_multi_busy  out  1  a multi-cycle op is occupying EX.

Behaviour:
- Reset: while rst_n is low, state = RUN, count = 0, all *_en = 0, all *_flush = 0, ex_multi_busy = 0. Reset takes effect immediately and aborts any in-progress stall. The first enables assert combinationally once rst_n is high.
- FSM state and counter are registered; outputs are combinational from state, count and inputs. Zero-cycle decision latency.
- States: RUN, MEM_WAIT, MULTI.
- Priority when several conditions hold: mem stall > MULTI > branch > load-use.
- mem_stall = mem_req & ~mem_ready.
  - In any state, mem_stall drives all *_en = 0 and all *_flush = 0 (global freeze).
  - RUN -> MEM_WAIT on mem_stall. MEM_WAIT returns to the saved prior state (RUN or MULTI) in the cycle mem_ready is high.
  - The MULTI count is frozen while in MEM_WAIT.
- RUN with no hazard: all *_en = 1, all *_flush = 0.
- Load-use hazard:
  - Condition: ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1; the other enables stay 1.
  - Lasts exactly one cycle, because the load then advances to MEM.
- Taken branch:
  - Response: if_id_flush = 1, id_ex_flush = 1, all *_en = 1.
  - Overrides load-use in the same cycle; the PC is not held, so the redirect is taken.
- Multi-cycle op: RUN -> MULTI when ex_multi_start is high and there is no mem_stall; count loads MULTI_LAT-2.
  - Start cycle and every MULTI cycle: pc_en = if_id_en = id_ex_en = 0, ex_mem_en = 1, ex_mem_flush = 1, mem_wb_en = 1.
  - This holds EX and inserts bubbles into EX/MEM.
  - In MULTI, count decrements each non-frozen cycle. When count == 0, the cycle is released with all *_en = 1 and no flushes, and the next state is RUN.
  - Total EX occupancy is exactly MULTI_LAT cycles.
  - ex_multi_busy = 1 in the start cycle and in MULTI, excluding the release cycle.
  - ex_branch_taken and ex_multi_start are ignored while in MULTI.
- Flush with the register's enable at 0 has no effect; the hold wins.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32 bits), which counts cycles where pc_en = 0, and perf_flush_cnt (32 bits), which counts cycles where if_id_flush = 1.
  - Both counters are registered, cleared by rst_n, and wrap at 2^32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum typedef (RUN, MEM_WAIT, MULTI);
  - the typedef stage_ctrl_t, a struct of the five enables and three flushes;
  - localparam REG_ZERO = '0.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator. The FSM, counter and output muxing stay in pipeline_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1, then all enables 1. Repeat with ex_rd = 0 -> no stall.
- Branch + load-use in the same cycle: ex_branch_taken = 1 and hazard true -> if_id_flush = id_ex_flush = 1, pc_en = 1.
- Multi-cycle, MULTI_LAT = 4: ex_multi_start pulse -> id_ex_en = 0 and ex_mem_flush = 1 for 3 cycles, ex_multi_busy high for 3 cycles, release on the 4th cycle, then RUN.
- Memory wait during MULTI: mem_req = 1, mem_ready = 0 for 2 cycles at MULTI count = 1 -> all en = 0 for those 2 cycles; release occurs 2 cycles later than without the wait.
- Reset mid-MULTI: rst_n low asynchronously -> outputs go to 0 immediately; after release, state is RUN, a fresh multi op takes a full 4 cycles, and with the macro defined both perf counters read 0.
